uart_tx_arbiter: RTL and testbench

- Shares one uart_tx byte transmitter among NUM_REQ requesters, using round-robin arbitration with packet locking.
- Each requester offers bytes on a valid/ready handshake and marks the final byte of a packet with req_last.
- The block sequences the transmitter's tx_start / busy / done handshake so each accepted byte is sent as exactly one frame.
- A locked owner that stalls mid-packet is released after LOCK_TIMEOUT idle cycles.

---
 rtl/uart_tx_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx byte transmitter among NUM_REQ requesters.
// Packets hold the grant until their last byte is sent, or until a stalled owner times out.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned LOCK_TIMEOUT = 1024,
    parameter int unsigned GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           enable,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [DATA_BITS-1:0]           tx_data,
    output logic                           tx_start,
    input  logic                           tx_busy,
    input  logic                           tx_done,
    output logic                           grant_valid,
    output logic [GW-1:0]                  grant_id,
    output logic                           lock_timeout
);

    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_MAX = TW'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEL       = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3
    } state_e;

    state_e               state_q, state_d;
    logic [GW-1:0]        rr_q, rr_d;
    logic [GW-1:0]        grant_id_q, grant_id_d;
    logic                 grant_valid_q, grant_valid_d;
    logic                 lock_q, lock_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
    logic                 tx_start_q, tx_start_d;
    logic                 lock_timeout_q, lock_timeout_d;

    logic                 rr_hit;
    logic [GW-1:0]        rr_win;
    int unsigned          cand;
    logic                 sel_valid;
    logic                 sel_last;
    logic [DATA_BITS-1:0] sel_data;
    logic                 frame_end;

    function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] idx);
        if (32'(idx) + 32'd1 >= NUM_REQ) begin
            return '0;
        end
        return idx + GW'(1);
    endfunction

    // First valid requester at or above the rr pointer, wrapping around.
    always_comb begin
        rr_hit = 1'b0;
        rr_win = rr_q;
        cand   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!rr_hit && req_valid[GW'(cand)]) begin
                rr_hit = 1'b1;
                rr_win = GW'(cand);
            end
        end
    end

    // Current owner's request lane.
    always_comb begin
        sel_valid = req_valid[grant_id_q];
        sel_last  = req_last[grant_id_q];
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_id_q == GW'(i)) begin
                sel_data = req_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        grant_id_d     = grant_id_q;
        grant_valid_d  = grant_valid_q;
        lock_d         = lock_q;
        timer_d        = timer_q;
        req_ready_d    = '0;
        tx_data_d      = tx_data_q;
        tx_start_d     = 1'b0;
        lock_timeout_d = 1'b0;
        frame_end      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (lock_q) begin
                    if (sel_valid) begin
                        state_d = S_SEL;
                        timer_d = '0;
                    end else if (timer_q == TIMER_MAX) begin
                        lock_d         = 1'b0;
                        grant_valid_d  = 1'b0;
                        lock_timeout_d = 1'b1;
                        timer_d        = '0;
                        rr_d           = next_idx(grant_id_q);
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end else if (rr_hit) begin
                    grant_id_d    = rr_win;
                    grant_valid_d = 1'b1;
                    state_d       = S_SEL;
                end
            end
            S_SEL: begin
                tx_data_d   = sel_data;
                tx_start_d  = 1'b1;
                req_ready_d = NUM_REQ'(1) << grant_id_q;
                lock_d      = !sel_last;
                state_d     = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_done) begin
                    frame_end = 1'b1;
                end else if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (tx_done) begin
                    frame_end = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Packet end releases the grant; mid-packet keeps owner for the next byte.
        if (frame_end) begin
            state_d = S_IDLE;
            if (!lock_q) begin
                rr_d          = next_idx(grant_id_q);
                grant_valid_d = 1'b0;
            end
        end

        if (!enable) begin
            state_d        = S_IDLE;
            lock_d         = 1'b0;
            timer_d        = '0;
            req_ready_d    = '0;
            tx_start_d     = 1'b0;
            grant_valid_d  = 1'b0;
            lock_timeout_d = 1'b0;
            rr_d           = rr_q;
            grant_id_d     = grant_id_q;
            tx_data_d      = tx_data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_q           <= '0;
            grant_id_q     <= '0;
            grant_valid_q  <= 1'b0;
            lock_q         <= 1'b0;
            timer_q        <= '0;
            req_ready_q    <= '0;
            tx_data_q      <= '0;
            tx_start_q     <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            grant_id_q     <= grant_id_d;
            grant_valid_q  <= grant_valid_d;
            lock_q         <= lock_d;
            timer_q        <= timer_d;
            req_ready_q    <= req_ready_d;
            tx_data_q      <= tx_data_d;
            tx_start_q     <= tx_start_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign tx_data      = tx_data_q;
    assign tx_start     = tx_start_q;
    assign grant_valid  = grant_valid_q;
    assign grant_id     = grant_id_q;
    assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester and transmitter models around the DUT, with an
// ordered scoreboard of expected {req_ready, tx_data, grant_id} per transmitted byte.
module tb_uart_tx_arbiter;

    localparam int unsigned NR       = 4;
    localparam int unsigned DB       = 8;
    localparam int unsigned LT       = 16;
    localparam int unsigned BUSY_LEN = 3;
    localparam int unsigned NVEC     = 13;

    logic              clk;
    logic              rst_n;
    logic              enable;
    logic [NR-1:0]     req_valid;
    logic [NR*DB-1:0]  req_data;
    logic [NR-1:0]     req_last;
    logic [NR-1:0]     req_ready;
    logic [DB-1:0]     tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic              tx_done;
    logic              grant_valid;
    logic [1:0]        grant_id;
    logic              lock_timeout;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .DATA_BITS    (DB),
        .LOCK_TIMEOUT (LT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id),
        .lock_timeout (lock_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned grp;
        int unsigned req;
        logic [7:0]  data;
        logic        last;
        logic [3:0]  exp_ready;
    } vec_t;

    typedef struct {
        logic [3:0]  ready;
        logic [7:0]  data;
        int unsigned id;
    } exp_t;

    vec_t        tbl [NVEC];
    exp_t        sb [$];
    logic [8:0]  rq_mem [NR][8];
    int          rq_head [NR];
    int          rq_tail [NR];
    int          checks, failures, cyc;
    int          done_tick, start_tick, lt_tick, lt_count, tx_cnt, t0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    task automatic push_exp(input logic [3:0] ready, input logic [7:0] data, input int unsigned id);
        exp_t e;
        e.ready = ready;
        e.data  = data;
        e.id    = id;
        sb.push_back(e);
    endtask

    task automatic push_req(input int unsigned r, input logic last, input logic [7:0] data);
        rq_mem[r][rq_tail[r]] = {last, data};
        rq_tail[r]++;
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            if (rq_tail[i] > rq_head[i]) begin
                req_valid[i]           = 1'b1;
                req_last[i]            = rq_mem[i][rq_head[i]][8];
                req_data[i*DB +: DB]   = rq_mem[i][rq_head[i]][7:0];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    task automatic tx_abort();
        tx_busy = 1'b0;
        tx_done = 1'b0;
        tx_cnt  = 0;
    endtask

    // One clock: observe outputs just after the edge, then advance the models.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (tx_start || (req_ready != '0)) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_grant");
            end else begin
                e = sb.pop_front();
                chk("tx_start", 32'(tx_start), 32'd1);
                chk("req_ready", 32'(req_ready), 32'(e.ready));
                chk("tx_data", 32'(tx_data), 32'(e.data));
                chk("grant_id", 32'(grant_id), e.id);
                chk("grant_valid", 32'(grant_valid), 32'd1);
                if (done_tick >= 0) begin
                    chk("start_gap_ge2", 32'((cyc - done_tick) >= 2), 32'd1);
                end
                start_tick = cyc;
            end
        end
        if (lock_timeout) begin
            lt_tick = cyc;
            lt_count++;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i] && (rq_tail[i] > rq_head[i])) begin
                rq_head[i]++;
            end
        end
        drive_reqs();
        tx_done = 1'b0;
        if (tx_start) begin
            tx_busy = 1'b1;
            tx_cnt  = BUSY_LEN;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                tx_busy   = 1'b0;
                tx_done   = 1'b1;
                done_tick = cyc;
            end
        end
    endtask

    task automatic run_to_idle(input string name);
        int n;
        n = 0;
        while ((sb.size() > 0 || tx_cnt > 0 || tx_done) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) begin
            fail_now({name, "_timeout"});
        end
        tick();
        tick();
    endtask

    task automatic wait_sb_empty(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) begin
            fail_now({name, "_timeout"});
        end
    endtask

    task automatic check_zero(input string name);
        chk({name, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({name, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({name, "_tx_start"}, 32'(tx_start), 32'd0);
        chk({name, "_grant_valid"}, 32'(grant_valid), 32'd0);
        chk({name, "_grant_id"}, 32'(grant_id), 32'd0);
        chk({name, "_lock_timeout"}, 32'(lock_timeout), 32'd0);
    endtask

    task automatic clear_models();
        for (int i = 0; i < NR; i++) begin
            rq_head[i] = 0;
            rq_tail[i] = 0;
        end
        sb.delete();
        tx_abort();
        done_tick = -1;
        lt_count  = 0;
        drive_reqs();
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        clear_models();
        #1;
        check_zero("reset");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic load_group(input int unsigned g);
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].grp == g) begin
                push_req(tbl[i].req, tbl[i].last, tbl[i].data);
                push_exp(tbl[i].exp_ready, tbl[i].data, tbl[i].req);
            end
        end
        drive_reqs();
    endtask

    initial begin
        // grp 0: round robin, grp 1: packet lock, grp 2: rr pointer after single byte from req 2
        tbl[0]  = '{0, 0, 8'h11, 1'b1, 4'b0001};
        tbl[1]  = '{0, 1, 8'h22, 1'b1, 4'b0010};
        tbl[2]  = '{0, 2, 8'h33, 1'b1, 4'b0100};
        tbl[3]  = '{0, 3, 8'h44, 1'b1, 4'b1000};
        tbl[4]  = '{0, 0, 8'h55, 1'b1, 4'b0001};
        tbl[5]  = '{1, 0, 8'h10, 1'b1, 4'b0001};
        tbl[6]  = '{1, 1, 8'hA1, 1'b0, 4'b0010};
        tbl[7]  = '{1, 1, 8'hA2, 1'b0, 4'b0010};
        tbl[8]  = '{1, 1, 8'hA3, 1'b1, 4'b0010};
        tbl[9]  = '{1, 3, 8'h30, 1'b1, 4'b1000};
        tbl[10] = '{1, 0, 8'h05, 1'b1, 4'b0001};
        tbl[11] = '{2, 3, 8'h3C, 1'b1, 4'b1000};
        tbl[12] = '{2, 0, 8'h0C, 1'b1, 4'b0001};

        checks     = 0;
        failures   = 0;
        cyc        = 0;
        start_tick = 0;
        lt_tick    = 0;
        req_valid  = '0;
        req_data   = '0;
        req_last   = '0;
        tx_busy    = 1'b0;
        tx_done    = 1'b0;
        enable     = 1'b1;
        rst_n      = 1'b1;
        #2;

        // Single byte: latency 2, then release and rr = 3.
        do_reset();
        push_req(2, 1'b1, 8'hA5);
        push_exp(4'b0100, 8'hA5, 2);
        drive_reqs();
        t0 = cyc;
        tick();
        chk("single_no_early_start", 32'(tx_start), 32'd0);
        run_to_idle("single");
        chk("single_latency", 32'(start_tick - t0), 32'd2);
        chk("single_grant_released", 32'(grant_valid), 32'd0);
        chk("single_grant_id_kept", 32'(grant_id), 32'd2);
        load_group(2);
        run_to_idle("rr_after_single");

        do_reset();
        load_group(0);
        run_to_idle("round_robin");

        do_reset();
        load_group(1);
        run_to_idle("packet_lock");

        // Lock timeout: req 2 stalls after a non-last byte, req 3 waits.
        do_reset();
        push_req(2, 1'b0, 8'h2A);
        push_req(3, 1'b1, 8'h3B);
        push_exp(4'b0100, 8'h2A, 2);
        drive_reqs();
        begin
            int n;
            n = 0;
            while (lt_count == 0 && n < 200) begin
                tick();
                n++;
            end
            if (n >= 200) begin
                fail_now("lock_timeout_wait");
            end
        end
        chk("lock_timeout_delay", 32'(lt_tick - done_tick), 32'(LT + 1));
        chk("lock_timeout_grant_dropped", 32'(grant_valid), 32'd0);
        tick();
        chk("lock_timeout_one_cycle", 32'(lock_timeout), 32'd0);
        push_exp(4'b1000, 8'h3B, 3);
        run_to_idle("after_timeout");
        chk("lock_timeout_count", 32'(lt_count), 32'd1);

        // Enable abort during WAIT_DONE of a locked packet.
        do_reset();
        push_req(0, 1'b1, 8'h01);
        push_req(0, 1'b1, 8'h02);
        push_req(1, 1'b0, 8'hB1);
        push_req(1, 1'b1, 8'hB2);
        push_exp(4'b0001, 8'h01, 0);
        push_exp(4'b0010, 8'hB1, 1);
        drive_reqs();
        wait_sb_empty("enable_pre");
        tick();
        tick();
        chk("enable_locked_grant_held", 32'(grant_valid), 32'd1);
        enable = 1'b0;
        tx_abort();
        tick();
        chk("enable_abort_grant", 32'(grant_valid), 32'd0);
        chk("enable_abort_start", 32'(tx_start), 32'd0);
        chk("enable_abort_grant_id", 32'(grant_id), 32'd1);
        repeat (4) tick();
        push_exp(4'b0010, 8'hB2, 1);
        push_exp(4'b0001, 8'h02, 0);
        enable = 1'b1;
        run_to_idle("enable_resume");

        // Asynchronous reset while waiting for busy.
        do_reset();
        push_req(2, 1'b0, 8'h77);
        push_exp(4'b0100, 8'h77, 2);
        drive_reqs();
        wait_sb_empty("midframe_pre");
        rst_n = 1'b0;
        tx_abort();
        #1;
        check_zero("async_rst");
        clear_models();
        push_req(1, 1'b1, 8'h11);
        push_req(3, 1'b1, 8'h33);
        drive_reqs();
        tick();
        tick();
        rst_n = 1'b1;
        push_exp(4'b0010, 8'h11, 1);
        push_exp(4'b1000, 8'h33, 3);
        run_to_idle("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
